// File: rtl/tdm_mux.sv
`default_nettype none
// ============================================================================
// Module   : tdm_mux
// Purpose  : N-to-1 round-robin time-division multiplexer. Collects single-word
//            valid/ready transfers from N input lanes and serialises them onto
//            one registered output stream tagged with the source lane index.
//            out_sel/out_data feed the matching 1xN demultiplexer directly.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            in_valid[N]    - per-lane request
//            in_data[N*W]   - packed lane data, lane k at [k*W +: W]
//            in_ready[N]    - per-lane accept (one-hot or zero, combinational)
//            out_valid      - output register holds a word
//            out_data[W]    - data of the granted lane (registered)
//            out_sel[SW]    - index of the granted lane (registered)
//            out_ready      - downstream accepts the word this cycle
// Config   : TDM_MUX_FIXED_PRIORITY_EN - when defined, the round-robin pointer
//            is removed and the lowest-index valid lane always wins.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_mux #(
    parameter int  N  = 8,
    parameter int  W  = 1,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_sel,
    input  logic           out_ready
);

    logic          w_free;
    logic          w_grant;
    logic [N-1:0]  w_pick;
    logic [SW-1:0] w_win;
    logic [W-1:0]  w_win_data;

    logic          r_valid;
    logic [W-1:0]  r_data;
    logic [SW-1:0] r_sel;

`ifdef TDM_MUX_FIXED_PRIORITY_EN
    // Lowest-index valid lane always wins.
    assign w_pick = in_valid;
`else
    localparam logic [SW-1:0] c_last = SW'(N - 1);

    logic [SW-1:0] r_ptr;
    logic [N-1:0]  w_mask_hi;
    logic [N-1:0]  w_req_hi;

    // Lanes at or above the pointer are searched first; if none of them is
    // valid the search wraps to the low lanes, so the lowest set bit of
    // w_pick is always the first valid lane in rotating order.
    for (genvar k = 0; k < N; k++) begin : g_mask
        assign w_mask_hi[k] = (SW'(k) >= r_ptr);
    end

    assign w_req_hi = in_valid & w_mask_hi;
    assign w_pick   = (|w_req_hi) ? w_req_hi : in_valid;

    // Explicit wrap keeps the pointer below N for non-power-of-two lane counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            r_ptr <= (w_win == c_last) ? '0 : w_win + SW'(1);
        end
    end
`endif

    // Slot is free when empty or when the held word drains this cycle, which
    // makes out_ready -> in_ready a purely combinational path.
    assign w_free  = !r_valid || out_ready;
    assign w_grant = w_free && (|in_valid) && !rst;

    always_comb begin
        w_win      = '0;
        w_win_data = '0;
        in_ready   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_pick[k]) begin
                w_win = SW'(k);
            end
        end
        for (int k = 0; k < N; k++) begin
            if (w_win == SW'(k)) begin
                w_win_data  = in_data[k*W +: W];
                in_ready[k] = w_grant;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
        end else if (w_grant) begin
            r_valid <= 1'b1;
            r_data  <= w_win_data;
            r_sel   <= w_win;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_sel   = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_tdm_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_mux
// Purpose  : Self-checking bench for tdm_mux. Drives an N=8/W=1 instance and
//            an N=5/W=4 instance, comparing against a lane-search reference
//            model that walks lanes (ptr+j) mod N with plain arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // N=8, W=1 instance
    logic       rst8 = 1'b1;
    logic [7:0] in_valid8 = '0;
    logic [7:0] in_data8 = '0;
    logic [7:0] in_ready8;
    logic       out_valid8;
    logic [0:0] out_data8;
    logic [2:0] out_sel8;
    logic       out_ready8 = 1'b0;

    // N=5, W=4 instance
    logic        rst5 = 1'b1;
    logic [4:0]  in_valid5 = '0;
    logic [19:0] in_data5 = '0;
    logic [4:0]  in_ready5;
    logic        out_valid5;
    logic [3:0]  out_data5;
    logic [2:0]  out_sel5;
    logic        out_ready5 = 1'b0;

    tdm_mux #(.N(8), .W(1)) u_dut8 (
        .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_data(in_data8),
        .in_ready(in_ready8), .out_valid(out_valid8), .out_data(out_data8),
        .out_sel(out_sel8), .out_ready(out_ready8)
    );

    tdm_mux #(.N(5), .W(4)) u_dut5 (
        .clk(clk), .rst(rst5), .in_valid(in_valid5), .in_data(in_data5),
        .in_ready(in_ready5), .out_valid(out_valid5), .out_data(out_data5),
        .out_sel(out_sel5), .out_ready(out_ready5)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic       m_valid;
    logic [0:0] m_data;
    logic [2:0] m_sel;
    int         m_ptr;
    logic       m5_valid;
    logic [3:0] m5_data;
    logic [2:0] m5_sel;
    int         m5_ptr;

    function automatic int ref_win(input int ptr, input logic [31:0] v, input int n);
        int lane;
`ifdef TDM_MUX_FIXED_PRIORITY_EN
        ptr = 0;
`endif
        for (int j = 0; j < n; j++) begin
            lane = (ptr + j) % n;
            if (v[lane]) return lane;
        end
        return -1;
    endfunction

    function automatic logic [31:0] ref_ready(input logic r, input logic mv, input logic ordy,
                                              input int ptr, input logic [31:0] v, input int n);
        int w;
        if (r || !(!mv || ordy)) return 32'd0;
        w = ref_win(ptr, v, n);
        if (w < 0) return 32'd0;
        return 32'd1 << w;
    endfunction

    task automatic model_edge();
        int w;
        if (rst8) begin
            m_valid = 1'b0; m_data = '0; m_sel = '0; m_ptr = 0;
        end else begin
            w = ref_win(m_ptr, {24'b0, in_valid8}, 8);
            if ((!m_valid || out_ready8) && w >= 0) begin
                m_valid = 1'b1; m_data = in_data8[w]; m_sel = 3'(w); m_ptr = (w + 1) % 8;
            end else if (out_ready8) begin
                m_valid = 1'b0;
            end
        end
        if (rst5) begin
            m5_valid = 1'b0; m5_data = '0; m5_sel = '0; m5_ptr = 0;
        end else begin
            w = ref_win(m5_ptr, {27'b0, in_valid5}, 5);
            if ((!m5_valid || out_ready5) && w >= 0) begin
                m5_valid = 1'b1; m5_data = in_data5[w*4 +: 4]; m5_sel = 3'(w); m5_ptr = (w + 1) % 5;
            end else if (out_ready5) begin
                m5_valid = 1'b0;
            end
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic reset8();
        rst8 = 1'b1; in_valid8 = '0; out_ready8 = 1'b0;
        tick();
        rst8 = 1'b0;
    endtask

    task automatic test_reset();
        rst8 = 1'b1; in_valid8 = 8'hFF; in_data8 = 8'($urandom); out_ready8 = 1'b1;
        #1;
        n_checks++;
        if (in_ready8 !== 8'h00) begin n_fail++; $display("FAIL reset_in_ready: got %h want 00", in_ready8); end
        tick();
        n_checks++;
        if (out_valid8 !== 1'b0 || out_sel8 !== 3'd0 || out_data8 !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: got v=%b sel=%0d d=%b want v=0 sel=0 d=0", out_valid8, out_sel8, out_data8);
        end
        rst8 = 1'b0;
        #1;
        n_checks++;
        if (in_ready8 !== 8'h01) begin n_fail++; $display("FAIL reset_first_ready: got %h want 01", in_ready8); end
        tick();
        n_checks++;
        if (out_valid8 !== 1'b1 || out_sel8 !== 3'd0 || out_data8 !== in_data8[0]) begin
            n_fail++; $display("FAIL reset_first_grant: got v=%b sel=%0d d=%b want v=1 sel=0 d=%b", out_valid8, out_sel8, out_data8, in_data8[0]);
        end
    endtask

    task automatic test_sweep();
        reset8();
        out_ready8 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_valid8 = 8'd1 << k;
            in_data8  = 8'($urandom) | (8'd1 << k);
            #1;
            n_checks++;
            if (in_ready8 !== (8'd1 << k)) begin n_fail++; $display("FAIL sweep_ready lane %0d: got %h want %h", k, in_ready8, 8'd1 << k); end
            tick();
            n_checks++;
            if (out_valid8 !== 1'b1 || out_sel8 !== 3'(k) || out_data8 !== 1'b1) begin
                n_fail++; $display("FAIL sweep_out lane %0d: got v=%b sel=%0d d=%b want v=1 sel=%0d d=1", k, out_valid8, out_sel8, out_data8, k);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_sel;
        reset8();
        in_valid8 = 8'hFF; out_ready8 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data8 = 8'($urandom);
            #1;
            tick();
`ifdef TDM_MUX_FIXED_PRIORITY_EN
            exp_sel = 3'd0;
`else
            exp_sel = 3'(i % 8);
`endif
            n_checks++;
            if (out_sel8 !== exp_sel || out_data8 !== in_data8[exp_sel] || out_valid8 !== 1'b1) begin
                n_fail++; $display("FAIL round_robin step %0d: got sel=%0d d=%b want sel=%0d d=%b", i, out_sel8, out_data8, exp_sel, in_data8[exp_sel]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic d3;
        reset8();
        in_valid8 = 8'b0000_1000; in_data8 = 8'($urandom); out_ready8 = 1'b1;
        d3 = in_data8[3];
        #1;
        tick();
        n_checks++;
        if (out_sel8 !== 3'd3 || out_valid8 !== 1'b1) begin n_fail++; $display("FAIL bp_fill: got sel=%0d v=%b want sel=3 v=1", out_sel8, out_valid8); end
        in_valid8 = 8'b0101_0000; out_ready8 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data8 = 8'($urandom);
            #1;
            n_checks++;
            if (in_ready8 !== 8'h00) begin n_fail++; $display("FAIL bp_stall_ready cycle %0d: got %h want 00", i, in_ready8); end
            tick();
            n_checks++;
            if (out_valid8 !== 1'b1 || out_sel8 !== 3'd3 || out_data8 !== d3) begin
                n_fail++; $display("FAIL bp_stall_hold cycle %0d: got v=%b sel=%0d d=%b want v=1 sel=3 d=%b", i, out_valid8, out_sel8, out_data8, d3);
            end
        end
        out_ready8 = 1'b1;
        #1;
        n_checks++;
        if (in_ready8 !== 8'b0001_0000) begin n_fail++; $display("FAIL bp_release_ready: got %h want 10", in_ready8); end
        tick();
        n_checks++;
        if (out_sel8 !== 3'd4 || out_valid8 !== 1'b1) begin n_fail++; $display("FAIL bp_release_grant: got sel=%0d want 4", out_sel8); end
        in_valid8 = 8'b0100_0000;
        #1;
        n_checks++;
        if (in_ready8 !== 8'b0100_0000) begin n_fail++; $display("FAIL bp_next_ready: got %h want 40", in_ready8); end
        tick();
        n_checks++;
        if (out_sel8 !== 3'd6 || out_valid8 !== 1'b1) begin n_fail++; $display("FAIL bp_next_grant: got sel=%0d want 6", out_sel8); end
    endtask

    task automatic test_wrap_np2();
        rst5 = 1'b1; in_valid5 = '0; out_ready5 = 1'b0;
        tick();
        rst5 = 1'b0;
        in_valid5 = 5'b10000; in_data5 = 20'($urandom); out_ready5 = 1'b1;
        #1;
        n_checks++;
        if (in_ready5 !== 5'b10000) begin n_fail++; $display("FAIL wrap_ready4: got %b want 10000", in_ready5); end
        tick();
        n_checks++;
        if (out_sel5 !== 3'd4 || out_data5 !== in_data5[19:16]) begin
            n_fail++; $display("FAIL wrap_grant4: got sel=%0d d=%h want sel=4 d=%h", out_sel5, out_data5, in_data5[19:16]);
        end
        in_valid5 = 5'b10001;
        #1;
        n_checks++;
        if (in_ready5 !== 5'b00001) begin n_fail++; $display("FAIL wrap_ready0: got %b want 00001", in_ready5); end
        tick();
        n_checks++;
        if (out_sel5 !== 3'd0 || out_data5 !== in_data5[3:0]) begin
            n_fail++; $display("FAIL wrap_grant0: got sel=%0d d=%h want sel=0 d=%h", out_sel5, out_data5, in_data5[3:0]);
        end
        for (int i = 0; i < 60; i++) begin
            in_valid5 = 5'($urandom); in_data5 = 20'($urandom); out_ready5 = ($urandom_range(0, 3) != 0);
            #1;
            n_checks++;
            if ({27'b0, in_ready5} !== ref_ready(rst5, m5_valid, out_ready5, m5_ptr, {27'b0, in_valid5}, 5)) begin
                n_fail++; $display("FAIL wrap_rand_ready cycle %0d: got %b want %b", i, in_ready5,
                                   5'(ref_ready(rst5, m5_valid, out_ready5, m5_ptr, {27'b0, in_valid5}, 5)));
            end
            tick();
            n_checks++;
            if (out_valid5 !== m5_valid || out_sel5 !== m5_sel || out_data5 !== m5_data || out_sel5 > 3'd4) begin
                n_fail++; $display("FAIL wrap_rand_out cycle %0d: got v=%b sel=%0d d=%h want v=%b sel=%0d d=%h",
                                   i, out_valid5, out_sel5, out_data5, m5_valid, m5_sel, m5_data);
            end
        end
        out_ready5 = 1'b0; in_valid5 = '0;
    endtask

    task automatic test_mid_reset();
        reset8();
        in_valid8 = 8'b0000_0010; in_data8 = 8'($urandom); out_ready8 = 1'b1;
        #1;
        tick();
        out_ready8 = 1'b0; in_valid8 = 8'b0010_0100;
        #1;
        tick();
        n_checks++;
        if (out_valid8 !== 1'b1 || out_sel8 !== 3'd1) begin n_fail++; $display("FAIL midrst_pending: got v=%b sel=%0d want v=1 sel=1", out_valid8, out_sel8); end
        rst8 = 1'b1; out_ready8 = 1'b1;
        #1;
        n_checks++;
        if (in_ready8 !== 8'h00) begin n_fail++; $display("FAIL midrst_ready: got %h want 00", in_ready8); end
        tick();
        n_checks++;
        if (out_valid8 !== 1'b0 || out_sel8 !== 3'd0) begin n_fail++; $display("FAIL midrst_clear: got v=%b sel=%0d want v=0 sel=0", out_valid8, out_sel8); end
        rst8 = 1'b0;
        #1;
        n_checks++;
        if (in_ready8 !== 8'b0000_0100) begin n_fail++; $display("FAIL midrst_after_ready: got %h want 04", in_ready8); end
        tick();
        n_checks++;
        if (out_valid8 !== 1'b1 || out_sel8 !== 3'd2) begin n_fail++; $display("FAIL midrst_after_grant: got sel=%0d want 2", out_sel8); end
    endtask

    task automatic test_random();
        logic [7:0] exp_rdy;
        reset8();
        for (int i = 0; i < 400; i++) begin
            rst8       = ($urandom_range(0, 49) == 0);
            in_valid8  = 8'($urandom);
            in_data8   = 8'($urandom);
            out_ready8 = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = 8'(ref_ready(rst8, m_valid, out_ready8, m_ptr, {24'b0, in_valid8}, 8));
            n_checks++;
            if (in_ready8 !== exp_rdy || !$onehot0(in_ready8)) begin
                n_fail++; $display("FAIL rand_ready cycle %0d: got %h want %h", i, in_ready8, exp_rdy);
            end
            tick();
            n_checks++;
            if (out_valid8 !== m_valid || out_sel8 !== m_sel || out_data8 !== m_data) begin
                n_fail++; $display("FAIL rand_out cycle %0d: got v=%b sel=%0d d=%b want v=%b sel=%0d d=%b",
                                   i, out_valid8, out_sel8, out_data8, m_valid, m_sel, m_data);
            end
        end
        rst8 = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_valid = 1'b0; m_data = '0; m_sel = '0; m_ptr = 0;
        m5_valid = 1'b0; m5_data = '0; m5_sel = '0; m5_ptr = 0;
        @(negedge clk);
        test_reset();
        test_sweep();
        test_round_robin();
        test_backpressure();
        test_wrap_np2();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tdm_mux.md
# tdm_mux

N-to-1 round-robin time-division multiplexer: gathers single-word transfers from N independent input lanes and serialises them onto one output stream, tagging each word with its source lane index. It is the transmit-side counterpart to the 1xN demultiplexer. `out_sel` drives the demux `sel`, and `out_data` drives its `inpt`, so lane *k* at the far end receives exactly what lane *k* sent here. It uses valid/ready handshakes on both sides and has a one-entry registered output stage.

## Interface
- `N`, default 8: number of input lanes, ≥2, not required to be a power of two.
- `W`, default 1: data width per lane.
- `SW`, derived as `$clog2(N)`: width of the lane index.

Ports:
- `clk`  input  1: single clock; all logic on its rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `in_valid`  input  N: per-lane request; bit *k* means lane *k* offers `in_data[k*W +: W]`.
- `in_data`  input  N*W: packed lane data; lane *k* at bits `[k*W +: W]`.
- `in_ready`  output  N: per-lane accept, combinational, at most one bit set (one-hot or zero).
- `out_valid`  output  1: output register holds a word.
- `out_data`  output  W: registered data of the granted lane.
- `out_sel`  output  SW: registered index of the granted lane.
- `out_ready`  input  1: downstream accepts the word this cycle.

## Operation
- Transfer rule: lane *k* transfers when `in_valid[k] && in_ready[k]`. The output transfers when `out_valid && out_ready`.
- Slot free: `free = !out_valid || out_ready`.
- Arbitration happens when `free` is high. The search starts at pointer `ptr` and goes upward with wrap (`ptr`, `ptr+1`, …, `N-1`, `0`, …, `ptr-1`). The first lane with `in_valid` set wins and gets `in_ready[win]=1`.
- If `free` is low, or no lane is valid, then `in_ready = 0`.
- On a grant:
  - `out_data <= in_data[win]`, `out_sel <= win`, `out_valid <= 1`.
  - `ptr <= (win == N-1) ? 0 : win+1`. Wrap is explicit, so non-power-of-two `N` never yields index ≥ N.
- No grant but the output transfers: `out_valid <= 0`; `ptr` unchanged.
- No grant and no output transfer: all registers hold.
- The output register is stable while `out_valid && !out_ready`. `out_data` and `out_sel` must not change.
- States are implicit: EMPTY (`out_valid=0`) and FULL (`out_valid=1`).
  - EMPTY→FULL on grant.
  - FULL→FULL on grant with `out_ready`, or on stall.
  - FULL→EMPTY on `out_ready` with no grant.
- `in_ready` never depends on `in_valid` of the same lane in a way that forms a combinational loop with upstream. Upstream must not make `in_valid` depend on `in_ready`.

## Timing
- Reset (synchronous, `rst=1` at a rising edge):
  - `out_valid=0`, `out_data=0`, `out_sel=0`, `ptr=0`.
  - `in_ready=0` while `rst` is high.
- Reset mid-operation: a pending output word is discarded, and no handshake is honoured in the reset cycle.
- Latency: input accept to `out_valid` is 1 cycle.
- Throughput: 1 word/cycle when `out_ready` is held high. Simultaneous output drain and new grant in the same cycle is required.
- Fairness: with all lanes continuously valid and `out_ready=1`, the grant order is 0,1,…,N-1,0,…, each lane once per N cycles.
- The backpressure path `out_ready`→`in_ready` is combinational.

## Configuration
- `TDM_MUX_FIXED_PRIORITY_EN`
  - Defined: the round-robin pointer is removed and the search always starts at lane 0, so the lowest-index valid lane wins; `ptr` logic is not synthesised.
  - Undefined (default): round-robin as specified above.
- Reset values, handshake rules and latency are identical in both builds.

## Test plan
- Reset: drive `rst=1` with all `in_valid` high → `out_valid=0`, `out_sel=0`, `out_data=0`, `in_ready=0`; first grant after release is lane 0.
- Sweep (N=8, W=1): each cycle raise only `in_valid[k]` with `in_data[k]=1`, for k=0..7, with `out_ready=1` → next cycle `out_sel=k`, `out_data=1`. Feeding the 1xN demux yields `out` one-hot at bit *k*.
- Round-robin: all 8 lanes valid continuously, `out_ready=1` → `out_sel` sequence 0,1,…,7,0,1. With `TDM_MUX_FIXED_PRIORITY_EN` defined → constant `out_sel=0`.
- Backpressure: fill the output with lane 3, hold `out_ready=0` for 5 cycles while lanes 4 and 6 are valid → `in_ready=0`, and `out_sel=3` and `out_data` stay stable. Release → lane 4 is granted in the same cycle as the drain, then lane 6.
- Wrap, non-power-of-two: N=5, only lane 4 valid, then lanes 0 and 4 valid → after the lane-4 grant `ptr` wraps to 0, lane 0 is granted next, and `out_sel` never exceeds 4.
- Mid-stream reset: assert `rst` while `out_valid=1` and lanes 2 and 5 are valid → next cycle `out_valid=0`; after release the first grant is lane 2 (`ptr=0`).
